shift_p_to_s_stream: RTL and testbench
======================================

# shift_p_to_s_stream

Parametrised parallel-to-serial shifter for the microprocessor's serial output path. Accepts WIDTH-bit words via a valid/ready handshake, buffers one word behind the word being shifted, and emits bits one per enabled clock with valid/last framing. Supports MSB-first or LSB-first order and a sink-side stall (shift_en). Back-to-back words stream with no idle gap.

## Interface
- WIDTH, 8: bits per word; must be at least 2.
- LSB_FIRST, 0: 0 = bit WIDTH-1 sent first; 1 = bit 0 sent first.
- IDLE_BIT, 1: level driven on sOut while sValid = 0.
- Clock  input  1  single clock; all state changes on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- data  input  WIDTH  parallel word, sampled on the accepting edge.
- load_valid  input  1  data is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  sink consumes the current bit at this edge.
- sOut  output  1  current serial bit.
- sValid  output  1  sOut carries a data bit.
- sLast  output  1  current bit is the final bit of its word.
- busy  output  1  a word is shifting or held.

## Operation
- State: shift register shreg[WIDTH], bit counter cnt (0..WIDTH-1, width $clog2(WIDTH)), mode IDLE/SHIFT, holding register hold[WIDTH] with flag hold_full.
- Accept = load_valid & load_ready at a posedge with Reset_n high.
- load_ready = !hold_full. Combinational from registered state only; no path from shift_en or load_valid.
- IDLE: accept loads data into shreg, cnt <= 0, mode <= SHIFT. hold stays empty.
- SHIFT, no consume (shift_en = 0): shreg and cnt hold. An accept writes hold and sets hold_full.
- SHIFT, consume, cnt < WIDTH-1: shreg shifts toward the output end, cnt++. An accept writes hold.
- SHIFT, consume, cnt = WIDTH-1 (last bit):
  - If hold_full: shreg <= hold, cnt <= 0, hold_full <= 0, stay in SHIFT. No accept is possible (ready = 0).
  - Else if accept: shreg <= data directly, cnt <= 0, stay in SHIFT.
  - Else: mode <= IDLE.
- sOut = shreg[WIDTH-1] when LSB_FIRST = 0, or shreg[0] when LSB_FIRST = 1, while in SHIFT. Otherwise sOut = IDLE_BIT.
- sValid = (mode == SHIFT).
- sLast = sValid & (cnt == WIDTH-1).
- busy = sValid | hold_full.
- Invariant: hold_full implies SHIFT. Verification asserts this.
- Words leave in acceptance order. No word is dropped or duplicated.

## Timing
- Reset (Reset_n low, asynchronous) gives: mode IDLE, cnt 0, shreg 0, hold_full 0, sOut = IDLE_BIT, sValid 0, sLast 0, busy 0, load_ready 1. No accept occurs while Reset_n is low.
- Reset mid-word discards the shifting and held words immediately. There is no partial output after release.
- Latency: a word accepted at edge N has its first bit on sOut after edge N, i.e. during cycle N+1.
- With shift_en held at 1, a word occupies exactly WIDTH cycles.
- Streaming: a new word accepted within each WIDTH-cycle window gives continuous sValid with no gap.
- Peak capacity is 2 words: one shifting, one held. The third word stalls via load_ready = 0 until the held word moves into shreg.
- load_ready rises the cycle after hold moves into shreg.
- shift_en = 0 freezes sOut, sLast and cnt for any number of cycles. shift_en has no effect in IDLE.

## Test plan
- Reset release, WIDTH=8, MSB-first: sOut = 1, sValid = 0, load_ready = 1. Accept 0xA5 → sOut over cycles 1..8 = 1,0,1,0,0,1,0,1; sLast only in cycle 8; sValid = 0 and busy = 0 in cycle 9.
- Back-to-back: accept 0xA5, then accept 0x3C one cycle later (goes to hold) → 16 consecutive valid bits 10100101 00111100. sLast in cycles 8 and 16. load_ready = 0 from cycle 2 to cycle 8, back to 1 in cycle 9.
- Backpressure: with hold full, assert load_valid with 0xFF → not accepted until load_ready = 1, then emitted as the third word, intact and in order.
- Stall: during 0xA5, drop shift_en for 3 cycles at bit 4 → sOut stays 0 and cnt is frozen; the remaining bits resume as 0,1,0,1 once shift_en returns.
- LSB_FIRST=1, IDLE_BIT=0: accept 0x0F → 1,1,1,1,0,0,0,0; sOut = 0 when idle.
- Reset mid-word: Reset_n low at bit 3 with hold full → within the same cycle sValid = 0, busy = 0, load_ready = 1, sOut = IDLE_BIT. After release, a new word 0x81 is emitted cleanly as 1,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/shift_p_to_s_stream.sv
// Parallel-to-serial shifter: one word shifting plus one word held, streamed
// gap-free with valid/last framing and a sink-side stall.
module shift_p_to_s_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sOut,
    output logic             sValid,
    output logic             sLast,
    output logic             busy
);

    // state   | meaning
    // S_IDLE  | nothing on sOut, shreg empty, hold always empty
    // S_SHIFT | shreg is on sOut, cnt = index of the bit currently driven
    typedef enum logic {S_IDLE, S_SHIFT} mode_e;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;

    assign load_ready = !hold_full_q;
    assign accept     = load_valid && load_ready;

    always_comb begin
        mode_d      = mode_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (mode_q)
            S_IDLE: begin
                if (accept) begin
                    shreg_d = data;
                    cnt_d   = '0;
                    mode_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (shift_en && cnt_q == LAST) begin
                    // Last bit leaves: refill from hold first, else straight from the input.
                    if (hold_full_q) begin
                        shreg_d     = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        shreg_d = data;
                        cnt_d   = '0;
                    end else begin
                        cnt_d  = '0;
                        mode_d = S_IDLE;
                    end
                end else begin
                    if (shift_en) begin
                        shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                        cnt_d   = cnt_q + CW'(1);
                    end
                    if (accept) begin
                        hold_d      = data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: mode_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q      <= S_IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sValid = (mode_q == S_SHIFT);
    assign sOut   = sValid ? (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]) : IDLE_BIT;
    assign sLast  = sValid && (cnt_q == LAST);
    assign busy   = sValid || hold_full_q;

endmodule

// File: tb/tb_shift_p_to_s_stream.sv
// Directed bench for shift_p_to_s_stream: MSB-first instance (a) and
// LSB-first / idle-low instance (b) sharing clock and reset.
module tb_shift_p_to_s_stream;

    logic       Clock;
    logic       Reset_n;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_shift, b_shift;
    logic       a_ready, a_sout, a_svalid, a_slast, a_busy;
    logic       b_ready, b_sout, b_svalid, b_slast, b_busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  w8;
    logic [15:0] w16;
    logic [23:0] w24;
    logic [10:0] wst;

    shift_p_to_s_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .data(a_data), .load_valid(a_valid),
        .load_ready(a_ready), .shift_en(a_shift), .sOut(a_sout), .sValid(a_svalid),
        .sLast(a_slast), .busy(a_busy)
    );

    shift_p_to_s_stream #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .data(b_data), .load_valid(b_valid),
        .load_ready(b_ready), .shift_en(b_shift), .sOut(b_sout), .sValid(b_svalid),
        .sLast(b_slast), .busy(b_busy)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; land at the negedge, where outputs are stable, and check the
    // hold-implies-shifting invariant on both instances.
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
        chk("inv_a", 32'(a_busy & ~a_svalid), 32'd0);
        chk("inv_b", 32'(b_busy & ~b_svalid), 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        a_data = '0; b_data = '0;
        a_valid = 1'b0; b_valid = 1'b0;
        a_shift = 1'b1; b_shift = 1'b1;
        repeat (2) @(negedge Clock);
        chk("rst_sout_a", a_sout, 1);
        chk("rst_sout_b", b_sout, 0);
        chk("rst_svalid", a_svalid, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_busy", a_busy, 0);
        Reset_n = 1'b1;
        step();
        chk("idle_sout", a_sout, 1);
        chk("idle_svalid", a_svalid, 0);
        chk("idle_ready", a_ready, 1);
        chk("idle_slast", a_slast, 0);

        // Single word 0xA5, MSB first
        a_data = 8'hA5; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        w8 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w1_bit%0d", i), a_sout, w8[7-i]);
            chk($sformatf("w1_last%0d", i), a_slast, (i == 7));
            chk($sformatf("w1_valid%0d", i), a_svalid, 1);
            step();
        end
        chk("w1_end_valid", a_svalid, 0);
        chk("w1_end_busy", a_busy, 0);
        chk("w1_end_sout", a_sout, 1);

        // Back-to-back 0xA5 then 0x3C into hold
        a_data = 8'hA5; a_valid = 1'b1;
        step();
        w16 = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b_bit%0d", i), a_sout, w16[15-i]);
            chk($sformatf("b2b_last%0d", i), a_slast, (i == 7 || i == 15));
            chk($sformatf("b2b_valid%0d", i), a_svalid, 1);
            chk($sformatf("b2b_ready%0d", i), a_ready, !(i >= 1 && i <= 7));
            if (i == 0) begin a_data = 8'h3C; a_valid = 1'b1; end
            if (i == 1) a_valid = 1'b0;
            step();
        end
        chk("b2b_end_valid", a_svalid, 0);
        chk("b2b_end_busy", a_busy, 0);

        // Backpressure: third word 0xFF waits for load_ready
        a_data = 8'hA5; a_valid = 1'b1;
        step();
        w24 = 24'hA53CFF;
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("bp_bit%0d", i), a_sout, w24[23-i]);
            chk($sformatf("bp_last%0d", i), a_slast, (i == 7 || i == 15 || i == 23));
            chk($sformatf("bp_valid%0d", i), a_svalid, 1);
            chk($sformatf("bp_ready%0d", i), a_ready,
                !((i >= 1 && i <= 7) || (i >= 9 && i <= 15)));
            if (i == 0) begin a_data = 8'h3C; a_valid = 1'b1; end
            if (i == 1) a_data = 8'hFF;
            if (i == 9) a_valid = 1'b0;
            step();
        end
        chk("bp_end_valid", a_svalid, 0);
        chk("bp_end_busy", a_busy, 0);

        // Stall: shift_en low for 3 cycles while bit 4 is on sOut
        a_data = 8'hA5; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        wst = 11'b10100000101;
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("st_bit%0d", i), a_sout, wst[10-i]);
            chk($sformatf("st_last%0d", i), a_slast, (i == 10));
            chk($sformatf("st_valid%0d", i), a_svalid, 1);
            if (i >= 3 && i <= 6) chk($sformatf("st_cnt%0d", i), dut_a.cnt_q, 3);
            if (i == 3) a_shift = 1'b0;
            if (i == 6) a_shift = 1'b1;
            step();
        end
        chk("st_end_valid", a_svalid, 0);

        // LSB-first instance, idle level 0: 0x0F
        chk("lsb_idle_sout", b_sout, 0);
        b_data = 8'h0F; b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        w8 = 8'h0F;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("lsb_bit%0d", i), b_sout, w8[i]);
            chk($sformatf("lsb_last%0d", i), b_slast, (i == 7));
            step();
        end
        chk("lsb_end_valid", b_svalid, 0);
        chk("lsb_end_sout", b_sout, 0);

        // Reset mid-word with hold full
        a_data = 8'hA5; a_valid = 1'b1;
        step();
        a_data = 8'h3C;
        step();
        a_valid = 1'b0;
        step();
        chk("mr_bit3", a_sout, 1);
        chk("mr_busy_pre", a_busy, 1);
        chk("mr_ready_pre", a_ready, 0);
        Reset_n = 1'b0;
        #1;
        chk("mr_valid", a_svalid, 0);
        chk("mr_busy", a_busy, 0);
        chk("mr_ready", a_ready, 1);
        chk("mr_sout", a_sout, 1);
        chk("mr_slast", a_slast, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
        chk("mr_rel_valid", a_svalid, 0);
        chk("mr_rel_busy", a_busy, 0);
        a_data = 8'h81; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        w8 = 8'h81;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("mr_w_bit%0d", i), a_sout, w8[7-i]);
            chk($sformatf("mr_w_last%0d", i), a_slast, (i == 7));
            step();
        end
        chk("mr_end_valid", a_svalid, 0);
        chk("mr_end_busy", a_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
